piso_shifter: RTL and testbench
===============================

PISO_SHIFTER -- requirements
Module: piso_shifter

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous assertion, active-low.
REQ-005 p_in  input  WIDTH  parallel word to serialize.
REQ-006 load_valid  input  1  p_in holds a word to send.
REQ-007 load_ready  output  1  block can accept a word this cycle.
REQ-008 s_ready  input  1  downstream consumes s_out this cycle.
REQ-009 s_out  output  1  current serial bit.
REQ-010 s_valid  output  1  s_out is a valid frame bit.
REQ-011 s_first  output  1  s_out is bit 0 of the frame (first sent).
REQ-012 s_last  output  1  s_out is the final bit of the frame.
REQ-013 busy  output  1  a frame is loaded and not yet fully consumed.

Function
REQ-014 Word accepted on a rising edge where load_valid=1 and load_ready=1; p_in captured into a WIDTH-bit shift register; bit counter set to WIDTH.
REQ-015 States: IDLE (no frame), SHIFT (frame bits pending); no other states.
REQ-016 IDLE: load_ready=1, s_valid=0, s_first=0, s_last=0, busy=0, s_out=0.
REQ-017 IDLE -> SHIFT on accept; first frame bit valid on s_out in the cycle after accept (latency 1).
REQ-018 SHIFT: s_valid=1, busy=1; s_out = shift-register bit WIDTH-1 if MSB_FIRST=1, else bit 0.
REQ-019 A bit is consumed on a rising edge where s_valid=1 and s_ready=1; shift register shifts one position toward the output end, counter decrements.
REQ-020 s_ready=0 in SHIFT: s_out, s_first, s_last, counter and register hold unchanged for any number of cycles.
REQ-021 s_first=1 only while counter=WIDTH; s_last=1 only while counter=1.
REQ-022 load_ready=1 in SHIFT only when s_last=1 and s_ready=1 (final bit being consumed); load_ready is combinational from registered state and s_ready only, never from load_valid.
REQ-023 Final bit consumed with no accept: SHIFT -> IDLE.
REQ-024 Final bit consumed with simultaneous accept: remain SHIFT, new word loaded, its first bit on s_out next cycle; zero idle cycles between frames.
REQ-025 load_valid while load_ready=0: ignored; p_in not sampled; no frame corruption.
REQ-026 s_ready in IDLE: ignored.
REQ-027 Exactly WIDTH bits emitted per accepted word; counter width ceil(log2(WIDTH+1)); counter never wraps below 0.
REQ-028 MSB_FIRST=1 output order matches serial_in_parallel_out input order: after WIDTH consumed bits, that receiver's s_out equals the transmitted p_in.

Reset
REQ-029 rst=0 immediately forces IDLE, shift register=0, counter=0, independent of clk.
REQ-030 During reset: s_out=0, s_valid=0, s_first=0, s_last=0, busy=0, load_ready=0.
REQ-031 A frame in progress at reset is discarded; no remaining bits emitted after release.
REQ-032 First accept possible on the first rising edge after rst returns high.

Verification
REQ-033 WIDTH=4, MSB_FIRST=1, s_ready=1, accept p_in=4'b1011 -> s_out 1,0,1,1 on cycles 1..4 after accept; s_first on cycle 1, s_last on cycle 4; IDLE on cycle 5.
REQ-034 Back-to-back: 4'b1011 then 4'b0110 with load_valid held -> 8 contiguous valid bits 1,0,1,1,0,1,1,0; s_valid never drops; second accept on cycle 4.
REQ-035 Stall: 4'b1100, s_ready=0 for 3 cycles after bit 2 -> s_out holds 1 (bit 2) with s_first=0, s_last=0 during stall; sequence resumes 1,0,0; total 4 bits.
REQ-036 Reset mid-frame: rst=0 asynchronously after 2 of 4 bits -> outputs 0 immediately without clock edge; after release, s_valid=0 until a new accept.
REQ-037 MSB_FIRST=0, accept 4'b0001 -> s_out 1,0,0,0.
REQ-038 Loopback into serial_in_parallel_out (WIDTH=4, clocked on consumed bits): 16 random words -> receiver parallel output equals each sent word after its 4th bit.

Source files
------------

// File: rtl/piso_shifter_if.sv
// Handshake and serial-stream bundle for piso_shifter.
// The slave modport is the shifter's view. The master modport is the view of the block that loads words and consumes bits.
interface piso_shifter_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] p_in;
    logic             load_valid;
    logic             load_ready;
    logic             s_ready;
    logic             s_out;
    logic             s_valid;
    logic             s_first;
    logic             s_last;
    logic             busy;

    modport master (
        output p_in, load_valid, s_ready,
        input  load_ready, s_out, s_valid, s_first, s_last, busy
    );

    modport slave (
        input  p_in, load_valid, s_ready,
        output load_ready, s_out, s_valid, s_first, s_last, busy
    );
endinterface

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shifter with valid/ready on both the load side and the serial side.
// A new word can be accepted on the cycle that consumes the final bit, so frames run back to back.
module piso_shifter #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    piso_shifter_if.slave   bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             valid_r;
    logic             first_r;
    logic             last_r;
    logic             accept;
    logic             consume;

    // rst is folded in so load_ready reads 0 while reset is asserted, even though the state is already IDLE.
    assign bus.load_ready = rst & ((state == IDLE) | (last_r & bus.s_ready));
    assign accept         = bus.load_valid & bus.load_ready;
    assign consume        = valid_r & bus.s_ready;

    assign bus.s_out   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign bus.s_valid = valid_r;
    assign bus.busy    = valid_r;
    assign bus.s_first = first_r;
    assign bus.s_last  = last_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            valid_r <= 1'b0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (accept) begin
            // A load takes priority: it is only possible from IDLE or while the final bit is consumed.
            state   <= SHIFT;
            sreg    <= bus.p_in;
            cnt     <= CW'(WIDTH);
            valid_r <= 1'b1;
            first_r <= 1'b1;
            last_r  <= 1'b0;
        end else if (consume) begin
            if (cnt == CW'(1)) begin
                state   <= IDLE;
                sreg    <= '0;
                cnt     <= '0;
                valid_r <= 1'b0;
                first_r <= 1'b0;
                last_r  <= 1'b0;
            end else begin
                sreg    <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
                cnt     <= cnt - CW'(1);
                first_r <= 1'b0;
                last_r  <= (cnt == CW'(2));
            end
        end
    end
endmodule

// File: tb/tb_piso_shifter.sv
// Randomized and directed bench for piso_shifter.
// A queue model holds the bits still owed for the current frame.
module tb_piso_shifter;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst;

    piso_shifter_if #(.WIDTH(W)) bus ();
    piso_shifter_if #(.WIDTH(W)) bus1 ();

    piso_shifter #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    piso_shifter #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int accepts = 0;
    int obs_n = 0;
    bit q[$];
    logic [W-1:0] sent[$];
    logic [W-1:0] rx = '0;
    logic [63:0] obs = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle. Outputs are checked at the falling edge, and the model advances at the rising edge.
    task automatic step();
        bit exp_ready;
        bit acc;
        bit con;
        bit sbit;
        logic [W-1:0] word;
        @(negedge clk);
        exp_ready = (q.size() == 0) || (q.size() == 1 && bus.s_ready);
        check_val("s_valid", bus.s_valid, q.size() != 0);
        check_val("busy", bus.busy, q.size() != 0);
        check_val("s_out", bus.s_out, (q.size() != 0) ? q[0] : 1'b0);
        check_val("s_first", bus.s_first, q.size() == W);
        check_val("s_last", bus.s_last, q.size() == 1);
        check_val("load_ready", bus.load_ready, exp_ready);
        acc  = bus.load_valid && exp_ready;
        con  = (q.size() != 0) && bus.s_ready;
        sbit = bus.s_out;
        word = bus.p_in;
        @(posedge clk);
        if (con) begin
            rx  = {rx[W-2:0], sbit};
            obs = {obs[62:0], sbit};
            obs_n++;
            void'(q.pop_front());
            if (q.size() == 0) begin
                if (sent.size() == 0) check_val("loopback_word_missing", 1, 0);
                else check_val("loopback", rx, sent.pop_front());
            end
        end
        if (acc) begin
            for (int i = W - 1; i >= 0; i--) q.push_back(word[i]);
            sent.push_back(word);
            accepts++;
        end
        #1;
    endtask

    initial begin
        logic [W-1:0] lsb_word;
        int start;
        rst = 1'b0;
        bus.p_in = '0; bus.load_valid = 1'b0; bus.s_ready = 1'b0;
        bus1.p_in = '0; bus1.load_valid = 1'b0; bus1.s_ready = 1'b0;
        #2;
        check_val("rst_s_out", bus.s_out, 0);
        check_val("rst_s_valid", bus.s_valid, 0);
        check_val("rst_s_first", bus.s_first, 0);
        check_val("rst_s_last", bus.s_last, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_load_ready", bus.load_ready, 0);
        @(posedge clk); #1 rst = 1'b1;

        // Single frame, accepted on the first edge after reset release.
        obs = '0; obs_n = 0;
        bus.p_in = 4'b1011; bus.load_valid = 1'b1; bus.s_ready = 1'b1;
        step();
        check_val("first_accept", accepts, 1);
        bus.load_valid = 1'b0;
        repeat (5) step();
        check_val("frame_1011", obs[3:0], 4'b1011);
        check_val("frame_1011_len", obs_n, 4);

        // Back-to-back frames with load_valid held high.
        obs = '0; obs_n = 0;
        bus.p_in = 4'b1011; bus.load_valid = 1'b1;
        step();
        bus.p_in = 4'b0110;
        repeat (4) step();
        check_val("b2b_accepts", accepts, 3);
        bus.load_valid = 1'b0;
        repeat (5) step();
        check_val("b2b_bits", obs[7:0], 8'b10110110);
        check_val("b2b_len", obs_n, 8);

        // Stall for three cycles with the second bit on the output.
        obs = '0; obs_n = 0;
        bus.p_in = 4'b1100; bus.load_valid = 1'b1; bus.s_ready = 1'b0;
        step();
        bus.load_valid = 1'b0; bus.s_ready = 1'b1;
        step();
        bus.s_ready = 1'b0;
        repeat (3) step();
        bus.s_ready = 1'b1;
        repeat (4) step();
        check_val("stall_bits", obs[3:0], 4'b1100);
        check_val("stall_len", obs_n, 4);

        // Assert reset between clock edges after two of the four bits have been consumed.
        obs = '0; obs_n = 0;
        bus.p_in = 4'b1011; bus.load_valid = 1'b1;
        step();
        bus.load_valid = 1'b0;
        repeat (2) step();
        #2 rst = 1'b0;
        #1;
        check_val("arst_s_out", bus.s_out, 0);
        check_val("arst_s_valid", bus.s_valid, 0);
        check_val("arst_s_first", bus.s_first, 0);
        check_val("arst_s_last", bus.s_last, 0);
        check_val("arst_busy", bus.busy, 0);
        check_val("arst_load_ready", bus.load_ready, 0);
        q.delete(); sent.delete();
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) step();
        check_val("arst_no_tail", obs_n, 2);

        // LSB-first instance.
        lsb_word = 4'b0001;
        bus1.p_in = lsb_word; bus1.load_valid = 1'b1; bus1.s_ready = 1'b1;
        @(posedge clk); #1 bus1.load_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check_val("lsb_s_out", bus1.s_out, lsb_word[i]);
            check_val("lsb_s_valid", bus1.s_valid, 1);
            check_val("lsb_s_last", bus1.s_last, i == W - 1);
        end
        @(negedge clk);
        check_val("lsb_idle", bus1.s_valid, 0);
        @(posedge clk); #1;

        // Random traffic. Every completed frame is checked through the loopback receiver.
        start = accepts;
        for (int n = 0; n < 3000 && (accepts - start) < 40; n++) begin
            bus.p_in = W'($urandom);
            bus.load_valid = $urandom_range(0, 1) != 0;
            bus.s_ready = $urandom_range(0, 3) != 0;
            step();
        end
        check_val("rand_word_count", (accepts - start) >= 40, 1);
        bus.load_valid = 1'b0; bus.s_ready = 1'b1;
        repeat (W + 2) step();
        check_val("drain_sent_empty", sent.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
